// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns (gfedcba, 1 = lit), the illegal-digit code and the
// frame FSM states shared by seg7_reader and its pattern decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_PAT_0 = 7'b0111111;
  localparam logic [6:0] SEG_PAT_1 = 7'b0000110;
  localparam logic [6:0] SEG_PAT_2 = 7'b1011011;
  localparam logic [6:0] SEG_PAT_3 = 7'b1001111;
  localparam logic [6:0] SEG_PAT_4 = 7'b1100110;
  localparam logic [6:0] SEG_PAT_5 = 7'b1101101;
  localparam logic [6:0] SEG_PAT_6 = 7'b1111101;
  localparam logic [6:0] SEG_PAT_7 = 7'b0000111;
  localparam logic [6:0] SEG_PAT_8 = 7'b1111111;
  localparam logic [6:0] SEG_PAT_9 = 7'b1101111;

  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational 7-segment pattern to BCD digit; anything that is
// not one of the ten digit glyphs yields BCD_ILLEGAL with o_err set.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  always_comb begin
    o_bcd = BCD_ILLEGAL;
    o_err = 1'b0;
    case (i_seg)
      SEG_PAT_0: o_bcd = 4'd0;
      SEG_PAT_1: o_bcd = 4'd1;
      SEG_PAT_2: o_bcd = 4'd2;
      SEG_PAT_3: o_bcd = 4'd3;
      SEG_PAT_4: o_bcd = 4'd4;
      SEG_PAT_5: o_bcd = 4'd5;
      SEG_PAT_6: o_bcd = 4'd6;
      SEG_PAT_7: o_bcd = 4'd7;
      SEG_PAT_8: o_bcd = 4'd8;
      SEG_PAT_9: o_bcd = 4'd9;
      default:   o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: debounces each strobe of a multiplexed 7-segment display and presents
// complete decoded frames on a valid/ready port. Define SEG7_DP_EN to also frame dp.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
`ifdef SEG7_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_out,
`endif
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err,
  output logic                    overrun
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]              r_seg, r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_dig, r_dig_prev;
  logic [7:0]              r_cnt, w_cnt_next;
  logic                    w_same, w_capture, w_frame_done, w_load;
  logic [NUM_DIGITS-1:0]   w_cap_vec, w_mask_next, r_mask;
  logic [3:0]              w_dec_bcd;
  logic                    w_dec_err;
  logic [4*NUM_DIGITS-1:0] r_shadow, w_frame_bcd, r_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_err, w_frame_err;
  logic                    r_valid, r_err, r_overrun;
  state_t                  r_state;

`ifdef SEG7_DP_EN
  logic                    r_dp, r_dp_prev;
  logic [NUM_DIGITS-1:0]   r_shadow_dp, w_frame_dp, r_dp_out;
  assign w_same = (r_seg == r_seg_prev) && (r_dig == r_dig_prev) && (r_dp == r_dp_prev);
  assign dp_out = r_dp_out;
`else
  assign w_same = (r_seg == r_seg_prev) && (r_dig == r_dig_prev);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg      <= '0;
      r_seg_prev <= '0;
      r_dig      <= '0;
      r_dig_prev <= '0;
      r_cnt      <= '0;
`ifdef SEG7_DP_EN
      r_dp       <= 1'b0;
      r_dp_prev  <= 1'b0;
`endif
    end else begin
      r_seg      <= seg;
      r_seg_prev <= r_seg;
      r_dig      <= dig_sel;
      r_dig_prev <= r_dig;
      r_cnt      <= w_cnt_next;
`ifdef SEG7_DP_EN
      r_dp       <= dp;
      r_dp_prev  <= r_dp;
`endif
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_same)
      w_cnt_next = 8'd1;
    else if (r_cnt < STABLE)
      w_cnt_next = r_cnt + 8'd1;
  end

  // A reload straight to STABLE (STABLE_CYCLES == 1) also counts as reaching it.
  assign w_capture    = (w_cnt_next == STABLE) && ((r_cnt != STABLE) || !w_same) && $onehot(r_dig);
  assign w_cap_vec    = w_capture ? r_dig : '0;
  assign w_mask_next  = r_mask | w_cap_vec;
  assign w_frame_done = &w_mask_next;
  assign w_load       = w_frame_done && ((r_state == SCAN) || out_ready);

  seg7_pattern_decode u_decode (
    .i_seg (r_seg),
    .o_bcd (w_dec_bcd),
    .o_err (w_dec_err)
  );

  // The frame seen on the completing cycle includes the capture happening right now.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_frame
      assign w_frame_bcd[4*gi +: 4] = w_cap_vec[gi] ? w_dec_bcd : r_shadow[4*gi +: 4];
      assign w_frame_err[gi]        = w_cap_vec[gi] ? w_dec_err : r_shadow_err[gi];
`ifdef SEG7_DP_EN
      assign w_frame_dp[gi]         = w_cap_vec[gi] ? r_dp      : r_shadow_dp[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_mask       <= '0;
`ifdef SEG7_DP_EN
      r_shadow_dp  <= '0;
`endif
    end else begin
      r_shadow     <= w_frame_bcd;
      r_shadow_err <= w_frame_err;
      r_mask       <= w_frame_done ? '0 : w_mask_next;
`ifdef SEG7_DP_EN
      r_shadow_dp  <= w_frame_dp;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SCAN;
      r_valid   <= 1'b0;
      r_bcd     <= '0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
`ifdef SEG7_DP_EN
      r_dp_out  <= '0;
`endif
    end else begin
      if (w_load) begin
        r_bcd    <= w_frame_bcd;
        r_err    <= |w_frame_err;
`ifdef SEG7_DP_EN
        r_dp_out <= w_frame_dp;
`endif
      end
      case (r_state)
        SCAN: begin
          if (w_frame_done) begin
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (!w_frame_done) begin
              r_valid <= 1'b0;
              r_state <= SCAN;
            end
          end else if (w_frame_done) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign bcd_out   = r_bcd;
  assign out_valid = r_valid;
  assign err       = r_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: directed scans of a 4-digit display; expected frames go into a
// scoreboard queue that a negedge monitor drains whenever a frame is handed over.
module tb_seg7_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_sel = '0;
  logic [15:0] bcd_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        err;
  logic        overrun;

  seg7_reader #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [15:0] bcd;
    logic        err;
    int          at;    // expected cycle of the handover, -1 = not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b1000000;
    endcase
  endfunction

  // Monitor: checks held frames stay put and pops one expectation per handover.
  logic [15:0] held_bcd;
  logic        held_err;
  logic        held = 1'b0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (held) begin
        chk("hold_bcd", 32'(bcd_out), 32'(held_bcd));
        chk("hold_err", 32'(err), 32'(held_err));
      end
      if (out_ready) begin
        held = 1'b0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%h required=none", bcd_out);
        end else begin
          mon_e = sb.pop_front();
          $display("frame bcd=%h err=%b cyc=%0d", bcd_out, err, cyc);
          chk("frame_bcd", 32'(bcd_out), 32'(mon_e.bcd));
          chk("frame_err", 32'(err), 32'(mon_e.err));
          if (mon_e.at >= 0) chk("frame_latency", 32'(cyc), 32'(mon_e.at));
        end
      end else begin
        held     = 1'b1;
        held_bcd = bcd_out;
        held_err = err;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dig_sel = '0;
    seg     = '0;
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n, input int ready_at);
    dig_sel = d;
    seg     = s;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == ready_at) out_ready = 1'b1;
    end
  endtask

  // mode 0: no frame expected, 1: frame with latency check, 2: frame without.
  task automatic scan(input logic [15:0] digs, input int n, input int mode,
                      input logic [15:0] eb, input logic ee, input int ready_at);
    logic [3:0] sel;
    for (int p = 0; p < 4; p++) begin
      if (p == 3 && mode == 1) sb.push_back('{eb, ee, cyc + 5});
      if (p == 3 && mode == 2) sb.push_back('{eb, ee, -1});
      sel = 4'b0001 << p;
      drive(sel, pat(digs[4*p +: 4]), n, (p == 3) ? ready_at : 0);
    end
    dig_sel = '0;
    seg     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_bcd_out", 32'(bcd_out), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1;
    do_reset();
    out_ready = 1'b1;

    // Basic frame 4321 with one-cycle valid.
    scan(16'h4321, 6, 1, 16'h4321, 1'b0, 0);
    idle(3);

    // Illegal glyph on position 2.
    scan(16'h4F21, 6, 1, 16'h4F21, 1'b1, 0);
    idle(3);

    // Three-cycle dwell never captures.
    scan(16'h1234, 3, 0, 16'h0, 1'b0, 0);
    scan(16'h1234, 3, 0, 16'h0, 1'b0, 0);
    idle(4);
    chk("short_dwell_no_valid", 32'(out_valid), 32'h0);

    // Consumer stalled across two scans: first frame held, second dropped.
    out_ready = 1'b0;
    scan(16'h5678, 6, 2, 16'h5678, 1'b0, 0);
    scan(16'h9012, 6, 0, 16'h0, 1'b0, 0);
    idle(2);
    chk("stall_overrun", 32'(overrun), 32'h1);
    chk("stall_valid", 32'(out_valid), 32'h1);
    chk("stall_bcd", 32'(bcd_out), 32'h5678);
    out_ready = 1'b1;
    idle(3);
    chk("stall_valid_dropped", 32'(out_valid), 32'h0);
    chk("overrun_sticky", 32'(overrun), 32'h1);

    // Completion coincides with acceptance of the held frame.
    do_reset();
    out_ready = 1'b0;
    scan(16'h1357, 6, 2, 16'h1357, 1'b0, 0);
    scan(16'h2468, 6, 1, 16'h2468, 1'b0, 4);
    idle(3);
    chk("coincide_no_overrun", 32'(overrun), 32'h0);
    chk("coincide_valid_dropped", 32'(out_valid), 32'h0);

    // Multi-hot strobe must not fill the mask.
    do_reset();
    out_ready = 1'b1;
    drive(4'b0100, pat(4'd5), 6, 0);
    drive(4'b1000, pat(4'd6), 6, 0);
    drive(4'b0011, pat(4'd8), 10, 0);
    idle(3);
    chk("multi_hot_no_valid", 32'(out_valid), 32'h0);
    drive(4'b0001, pat(4'd9), 6, 0);
    sb.push_back('{16'h6579, 1'b0, cyc + 5});
    drive(4'b0010, pat(4'd7), 6, 0);
    idle(3);

    // Reset after three captures discards the partial frame.
    drive(4'b0001, pat(4'd1), 6, 0);
    drive(4'b0010, pat(4'd2), 6, 0);
    drive(4'b0100, pat(4'd3), 6, 0);
    idle(1);
    do_reset();
    scan(16'h8765, 6, 1, 16'h8765, 1'b0, 0);
    idle(3);

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
